ov7670_cfg_seq: RTL and testbench

- Power-up and register-configuration controller for the OV7670 camera port.
- Drives the pwdn and cam_rstn pins through the datasheet power-up timing, then walks an external configuration ROM of {reg, value} pairs.
- Issues one SCCB write per entry to the existing SCCB master through a req/ack/nack handshake.
- Raises done, which drives the board LED, or err, and sits between the top-level camera wrapper and the SCCB master.

---
 rtl/ov7670_pkg.sv | 36 +++
 rtl/ov7670_wait_cnt.sv | 30 +++
 rtl/ov7670_cfg_seq.sv | 205 ++++++++++++++++++++
 tb/tb_ov7670_cfg_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 power-up / configuration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ov7670_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PWDN,
    RSTL,
    WAKE,
    FETCH,
    DECODE,
    ISSUE,
    GAP,
    DELAY,
    DONE,
    ERROR
  } cfg_state_t;

  // ROM sentinels: end-of-table and "stall for DELAY_CYC"
  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  // OV7670 SCCB write address
  localparam logic [7:0] DEF_DEV_ID = 8'h42;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold (max_cyc - 1); never narrower than 1 bit
  function automatic int cnt_width(input int max_cyc);
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/ov7670_wait_cnt.sv
// Loadable down-counter shared by every timed state of the sequencer.
// Latency: load of (N-1) on value -> expired high in the Nth cycle after the load edge.
// Backpressure: none; load overrides counting, counting stops at zero.
//
// Ports: clk, rst (sync, active-high), load, value (cycles-1), expired (count == 0).
module ov7670_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ov7670_cfg_seq.sv
// OV7670 power-up and register-configuration controller: sequences pwdn/cam_rstn,
//   then walks a {reg,val} ROM issuing one SCCB write per entry, with NACK retry.
// Latency: reset release to first sccb_req = 1 + PWDN_CYC + RST_CYC + WAKE_CYC + 2 cycles.
// Backpressure: sccb_req held with stable reg/val until ack or nack; nack wins a tie.
//
// Ports: clk, rst (sync active-high), start (restart pulse, DONE/ERROR only),
//   rom_addr/rom_data (ROM, 1-cycle read), sccb_req/id/reg/val/ack/nack (SCCB master),
//   cam_rstn/pwdn (camera pins), done/err (status).
module ov7670_cfg_seq
  import ov7670_pkg::*;
#(
  parameter logic [7:0] DEV_ID    = DEF_DEV_ID,
  parameter int         ADDR_W    = 6,
  parameter int         PWDN_CYC  = 50000,
  parameter int         RST_CYC   = 50000,
  parameter int         WAKE_CYC  = 50000,
  parameter int         GAP_CYC   = 500,
  parameter int         DELAY_CYC = 500000,
  parameter int         MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_req,
  output logic [7:0]        sccb_id,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_val,
  input  logic              sccb_ack,
  input  logic              sccb_nack,
  output logic              cam_rstn,
  output logic              pwdn,
  output logic              done,
  output logic              err
);

  localparam int MAX_CYC = max2(max2(max2(PWDN_CYC, RST_CYC), max2(WAKE_CYC, GAP_CYC)), DELAY_CYC);
  localparam int CW      = cnt_width(MAX_CYC);
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Counter is loaded with cycles-1 so the widest load still fits in CW bits
  localparam logic [CW-1:0] PWDN_LD  = CW'(PWDN_CYC - 1);
  localparam logic [CW-1:0] RST_LD   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] WAKE_LD  = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] DELAY_LD = CW'(DELAY_CYC - 1);

  cfg_state_t state, next_state;

  logic [CW-1:0]     cnt_val;
  logic              cnt_load;
  logic              cnt_exp;
  logic [RW-1:0]     retry, retry_d;
  logic              acked, acked_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [7:0]        reg_d, val_d;
  logic              req_d, pwdn_d, rstn_d, done_d, err_d;
  logic              last_entry;
  logic              retry_left;

  assign last_entry = &rom_addr;
  assign retry_left = (retry < RW'(MAX_RETRY));
  assign sccb_id    = DEV_ID;

  ov7670_wait_cnt #(.W(CW)) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .value   (cnt_val),
    .expired (cnt_exp)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pwdn     <= 1'b1;
      cam_rstn <= 1'b0;
      sccb_req <= 1'b0;
      sccb_reg <= 8'h00;
      sccb_val <= 8'h00;
      rom_addr <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      retry    <= '0;
      acked    <= 1'b0;
    end else begin
      state    <= next_state;
      pwdn     <= pwdn_d;
      cam_rstn <= rstn_d;
      sccb_req <= req_d;
      sccb_reg <= reg_d;
      sccb_val <= val_d;
      rom_addr <= rom_addr_d;
      done     <= done_d;
      err      <= err_d;
      retry    <= retry_d;
      acked    <= acked_d;
    end
  end

  // Next-state logic. ack/nack are only looked at in ISSUE, where sccb_req is 1.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   next_state = PWDN;
      PWDN:   if (cnt_exp) next_state = RSTL;
      RSTL:   if (cnt_exp) next_state = WAKE;
      WAKE:   if (cnt_exp) next_state = FETCH;
      FETCH:  next_state = DECODE;
      DECODE: begin
        if (rom_data == CFG_END)        next_state = DONE;
        else if (rom_data == CFG_DELAY) next_state = DELAY;
        else                            next_state = ISSUE;
      end
      ISSUE: begin
        if (sccb_nack)     next_state = retry_left ? GAP : ERROR;
        else if (sccb_ack) next_state = GAP;
      end
      // Last ROM slot ends the run instead of wrapping
      GAP:    if (cnt_exp) next_state = (acked && last_entry) ? DONE : FETCH;
      DELAY:  if (cnt_exp) next_state = last_entry ? DONE : FETCH;
      DONE,
      ERROR:  if (start) next_state = PWDN;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping
  always_comb begin
    pwdn_d = 1'b0;
    rstn_d = 1'b1;
    case (next_state)
      IDLE, PWDN: begin
        pwdn_d = 1'b1;
        rstn_d = 1'b0;
      end
      RSTL: begin
        pwdn_d = 1'b0;
        rstn_d = 1'b0;
      end
      default: ;
    endcase

    req_d  = (next_state == ISSUE);
    done_d = (next_state == DONE);
    err_d  = (next_state == ERROR);

    // reg/val only change when a new write is launched, so they stay put across retries
    reg_d = sccb_reg;
    val_d = sccb_val;
    if (state == DECODE && next_state == ISSUE) begin
      reg_d = rom_data[15:8];
      val_d = rom_data[7:0];
    end

    rom_addr_d = rom_addr;
    retry_d    = retry;
    acked_d    = acked;
    case (state)
      ISSUE: begin
        if (sccb_nack) begin
          acked_d = 1'b0;
          if (retry_left) retry_d = retry + RW'(1);
        end else if (sccb_ack) begin
          acked_d = 1'b1;
        end
      end
      GAP: begin
        // A NACKed entry leaves rom_addr alone so FETCH re-reads it
        if (cnt_exp && acked) begin
          retry_d = '0;
          if (!last_entry) rom_addr_d = rom_addr + ADDR_W'(1);
        end
      end
      DELAY: begin
        if (cnt_exp && !last_entry) rom_addr_d = rom_addr + ADDR_W'(1);
      end
      DONE, ERROR: begin
        if (start) begin
          rom_addr_d = '0;
          retry_d    = '0;
          acked_d    = 1'b0;
        end
      end
      default: ;
    endcase

    // Timed states load the counter on entry
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (next_state != state) begin
      case (next_state)
        PWDN:  begin cnt_load = 1'b1; cnt_val = PWDN_LD;  end
        RSTL:  begin cnt_load = 1'b1; cnt_val = RST_LD;   end
        WAKE:  begin cnt_load = 1'b1; cnt_val = WAKE_LD;  end
        GAP:   begin cnt_load = 1'b1; cnt_val = GAP_LD;   end
        DELAY: begin cnt_load = 1'b1; cnt_val = DELAY_LD; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Self-checking bench for ov7670_cfg_seq with shortened timing parameters.
// Expected SCCB writes are queued per scenario and popped as requests appear.
module tb_ov7670_cfg_seq;
  import ov7670_pkg::*;

  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data = 16'h0000;
  logic              sccb_req;
  logic [7:0]        sccb_id, sccb_reg, sccb_val;
  logic              sccb_ack = 1'b0;
  logic              sccb_nack = 1'b0;
  logic              cam_rstn, pwdn, done, err;

  logic [15:0] rom [8];

  int n_pass = 0;
  int n_chk  = 0;
  int cyc, t_pwdn, t_rstn, t_req1, req_cnt;
  int gap_q[$];
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  // ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  ov7670_cfg_seq #(
    .DEV_ID    (8'h42),
    .ADDR_W    (ADDR_W),
    .PWDN_CYC  (4),
    .RST_CYC   (4),
    .WAKE_CYC  (4),
    .GAP_CYC   (2),
    .DELAY_CYC (8),
    .MAX_RETRY (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sccb_req  (sccb_req),
    .sccb_id   (sccb_id),
    .sccb_reg  (sccb_reg),
    .sccb_val  (sccb_val),
    .sccb_ack  (sccb_ack),
    .sccb_nack (sccb_nack),
    .cam_rstn  (cam_rstn),
    .pwdn      (pwdn),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pwdn === 1'b0 && t_pwdn < 0) t_pwdn = cyc;
    if (cam_rstn === 1'b1 && t_rstn < 0) t_rstn = cyc;
  endtask

  task automatic clear_stats();
    cyc = 0; t_pwdn = -1; t_rstn = -1; t_req1 = -1; req_cnt = 0;
    gap_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_wr(input int a, input logic [15:0] w);
    exp_q.push_back({8'(a), w});
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int k = 0; k < 8; k++) rom[k] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwdn", 32'(pwdn), 32'd1);
    check("rst_cam_rstn", 32'(cam_rstn), 32'd0);
    check("rst_req", 32'(sccb_req), 32'd0);
    check("rst_reg_val", 32'({sccb_reg, sccb_val}), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    rst = 1'b0;
    clear_stats();
  endtask

  // Plays the SCCB master: answers each request 3 cycles after it rises.
  // nack_n < 0 NACKs every request, otherwise the first nack_n requests are NACKed.
  task automatic serve(input int budget, input int nack_n);
    int idle;
    bit seen, stable, nk, finished;
    logic [23:0] e;
    logic [7:0] r0, v0;
    idle = 0; seen = 0; finished = 0;
    for (int i = 0; i < budget && !finished; i++) begin
      tick();
      if (done === 1'b1 || err === 1'b1) begin
        finished = 1;
      end else if (sccb_req === 1'b1) begin
        req_cnt++;
        if (t_req1 < 0) t_req1 = cyc;
        if (seen) gap_q.push_back(idle);
        seen = 1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(rom_addr), 32'(e[23:16]));
          check("wr_reg", 32'(sccb_reg), 32'(e[15:8]));
          check("wr_val", 32'(sccb_val), 32'(e[7:0]));
        end
        r0 = sccb_reg; v0 = sccb_val; stable = 1;
        nk = (nack_n < 0) || (req_cnt <= nack_n);
        repeat (2) begin
          tick();
          if (sccb_req !== 1'b1 || sccb_reg !== r0 || sccb_val !== v0) stable = 0;
        end
        if (nk) sccb_nack = 1'b1;
        else    sccb_ack  = 1'b1;
        tick();
        sccb_ack = 1'b0; sccb_nack = 1'b0;
        check("wr_hold", 32'(stable), 32'd1);
        check("req_drop", 32'(sccb_req), 32'd0);
        idle = 1;
      end else if (seen) begin
        idle++;
      end
    end
    check("finished", 32'(finished), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Power-up timing and basic two-write ROM
    fill_rom(CFG_END);
    rom[0] = 16'h1280; rom[1] = 16'h1204;
    do_reset();
    expect_wr(0, 16'h1280); expect_wr(1, 16'h1204);
    serve(200, 0);
    check("t_pwdn_fall", 32'(t_pwdn), 32'd5);
    check("t_rstn_rise", 32'(t_rstn), 32'd9);
    check("t_first_req", 32'(t_req1), 32'd15);
    check("basic_req_cnt", 32'(req_cnt), 32'd2);
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);
    check("basic_done_err", 32'({done, err}), 32'b10);
    check("basic_gap", 32'((gap_q.size() > 0) ? gap_q[0] : -1), 32'd4);
    check("basic_end_addr", 32'(rom_addr), 32'd2);
    check("basic_pins", 32'({pwdn, cam_rstn}), 32'b01);
    check("sccb_id", 32'(sccb_id), 32'h42);

    // Two NACKs then ACK on the first entry
    do_reset();
    expect_wr(0, 16'h1280); expect_wr(0, 16'h1280); expect_wr(0, 16'h1280);
    expect_wr(1, 16'h1204);
    serve(300, 2);
    check("retry_req_cnt", 32'(req_cnt), 32'd4);
    check("retry_q_empty", 32'(exp_q.size()), 32'd0);
    check("retry_done_err", 32'({done, err}), 32'b10);

    // NACK everything: 1 + MAX_RETRY attempts then ERROR
    do_reset();
    for (int k = 0; k < 4; k++) expect_wr(0, 16'h1280);
    serve(300, -1);
    check("exh_req_cnt", 32'(req_cnt), 32'd4);
    check("exh_done_err", 32'({done, err}), 32'b01);
    check("exh_req_low", 32'(sccb_req), 32'd0);

    // Delay token between two writes
    fill_rom(CFG_END);
    rom[0] = 16'h1101; rom[1] = CFG_DELAY; rom[2] = 16'h6B4A;
    do_reset();
    expect_wr(0, 16'h1101); expect_wr(2, 16'h6B4A);
    serve(300, 0);
    check("dly_req_cnt", 32'(req_cnt), 32'd2);
    check("dly_q_empty", 32'(exp_q.size()), 32'd0);
    check("dly_gap", 32'((gap_q.size() > 0) ? gap_q[0] : -1), 32'd14);
    check("dly_done", 32'(done), 32'd1);

    // start pulse in DONE re-runs the whole sequence from address 0
    @(negedge clk);
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_state", 32'({done, pwdn, cam_rstn}), 32'b010);
    check("restart_addr", 32'(rom_addr), 32'd0);
    expect_wr(0, 16'h1101); expect_wr(2, 16'h6B4A);
    serve(300, 0);
    check("restart_first_req", 32'(t_req1), 32'd15);
    check("restart_req_cnt", 32'(req_cnt), 32'd2);
    check("restart_done", 32'(done), 32'd1);

    // Full ROM with no sentinel: stops after the last slot
    for (int k = 0; k < 8; k++) rom[k] = {8'(8'h20 + k), 8'(8'h30 + k)};
    do_reset();
    for (int k = 0; k < 8; k++) expect_wr(k, {8'(8'h20 + k), 8'(8'h30 + k)});
    serve(400, 0);
    check("full_req_cnt", 32'(req_cnt), 32'd8);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);
    check("full_end_addr", 32'(rom_addr), 32'd7);
    check("full_done_err", 32'({done, err}), 32'b10);

    // Reset while a request is outstanding; a late ack must be ignored
    fill_rom(CFG_END);
    rom[0] = 16'h1280;
    do_reset();
    for (int i = 0; i < 100 && sccb_req !== 1'b1; i++) tick();
    check("mid_req_seen", 32'(sccb_req), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_req", 32'(sccb_req), 32'd0);
    check("mid_rst_pins", 32'({pwdn, cam_rstn}), 32'b10);
    rst = 1'b0;
    clear_stats();
    sccb_ack = 1'b1;
    tick();
    sccb_ack = 1'b0;
    expect_wr(0, 16'h1280);
    serve(200, 0);
    check("mid_first_req", 32'(t_req1), 32'd15);
    check("mid_req_cnt", 32'(req_cnt), 32'd1);
    check("mid_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
